// File: rtl/uart_pkg.sv
// Shared types and timing helpers for the UART transmit feeder.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_DONE
  } state_t;

  // newd is held for one UART clock period plus two system clocks
  localparam int unsigned HOLD_EXTRA   = 2;
  // a frame is abandoned after this many UART clock periods without done
  localparam int unsigned TIMEOUT_MULT = 16;

  function automatic int unsigned uclk_period(input int unsigned clk_freq,
                                              input int unsigned baud_rate);
    return 2 * ((clk_freq / baud_rate) / 2 + 1);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte FIFO with registered full/empty/level and same-cycle read data.
module uart_sync_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_nxt;
  logic          push;
  logic          pop;

  assign pop     = rd_en && !empty;
  // a write into a full FIFO still lands when a pop frees a slot this cycle
  assign push    = wr_en && (!full || pop);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + 1'b1;
    else if (pop && !push)
      level_nxt = level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == LW'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Queues bytes and hands them one at a time to a UART transmitter.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 1000000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               tx_data,
  output logic                     newd,
  input  logic                     donetx,
  output logic                     busy,
  output logic                     tx_timeout
);

  localparam int unsigned UCLK_PERIOD    = uclk_period(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HOLD_CYCLES    = UCLK_PERIOD + HOLD_EXTRA;
  localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_MULT * UCLK_PERIOD;
  localparam int unsigned HW             = $clog2(HOLD_CYCLES);
  localparam int unsigned TW             = $clog2(TIMEOUT_CYCLES);

  state_t        state;
  state_t        state_nxt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_nxt;
  logic [TW-1:0] to_cnt;
  logic [TW-1:0] to_nxt;
  logic          timeout_nxt;
  logic          pop_req;
  logic [7:0]    rd_data;
  logic          done_s1;
  logic          done_s2;
  logic          done_s3;
  logic          done_rise;

  uart_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop_req),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign newd      = (state == SEND);
  assign busy      = (state != IDLE);
  assign done_rise = done_s2 && !done_s3;

  // donetx comes from the baud clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_s1 <= 1'b0;
      done_s2 <= 1'b0;
      done_s3 <= 1'b0;
    end else begin
      done_s1 <= donetx;
      done_s2 <= done_s1;
      done_s3 <= done_s2;
    end
  end

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    to_nxt      = to_cnt;
    timeout_nxt = 1'b0;
    pop_req     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty)
          state_nxt = LOAD;
      end
      LOAD: begin
        pop_req   = 1'b1;
        hold_nxt  = '0;
        state_nxt = SEND;
      end
      SEND: begin
        if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          to_nxt    = '0;
          state_nxt = WAIT_DONE;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        // done wins over a coincident timeout
        if (done_rise) begin
          state_nxt = IDLE;
        end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
        end else begin
          to_nxt = to_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      to_cnt     <= '0;
      tx_timeout <= 1'b0;
      overflow   <= 1'b0;
      tx_data    <= '0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      to_cnt     <= to_nxt;
      tx_timeout <= timeout_nxt;
      // the only pop is the LOAD pop, and LOAD implies a non-empty FIFO
      overflow   <= wr_en && full && !pop_req;
      if (pop_req)
        tx_data <= rd_data;
    end
  end

endmodule
